// File: rtl/lif_output_monitor.sv
// Reader-side monitor for the LIF neuron: rebuilds vout/spike from the output pins,
// measures spike statistics over a programmable window and serves them byte-wise.
module lif_output_monitor #(
    parameter int WIN_W   = 16,
    parameter int CNT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       neu_uo,
    input  logic [7:0]       neu_uio,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [3:0]       rd_addr,
    input  logic             rd_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [15:0]      v_s_q, v_s_d;
    logic             sp_s_q, sp_s_d, sp_d_q, sp_d_d;
    logic [WIN_W-1:0] remaining_q, remaining_d;
    logic [WIN_W-1:0] elapsed_q, elapsed_d;
    logic [15:0]      since_q, since_d;
    logic             seen_q, seen_d;
    logic [7:0]       spike_cnt_q, spike_cnt_d;
    logic [15:0]      first_lat_q, first_lat_d;
    logic [15:0]      last_isi_q, last_isi_d;
    logic [15:0]      min_isi_q, min_isi_d;
    logic [15:0]      peak_v_q, peak_v_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             spike_ev;
    logic [7:0]       rd_byte;

    // Rising edge of the registered spike pin; a held-high spike counts once.
    assign spike_ev = sp_s_q & ~sp_d_q;

    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            4'd0:    rd_byte = spike_cnt_q;
            4'd1:    rd_byte = first_lat_q[15:8];
            4'd2:    rd_byte = first_lat_q[7:0];
            4'd3:    rd_byte = last_isi_q[15:8];
            4'd4:    rd_byte = last_isi_q[7:0];
            4'd5:    rd_byte = min_isi_q[15:8];
            4'd6:    rd_byte = min_isi_q[7:0];
            4'd7:    rd_byte = peak_v_q[15:8];
            4'd8:    rd_byte = peak_v_q[7:0];
            4'd9:    rd_byte = {5'b0, seen_q, state_q == RUN, state_q == HOLD};
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        elapsed_d   = elapsed_q;
        since_d     = since_q;
        seen_d      = seen_q;
        spike_cnt_d = spike_cnt_q;
        first_lat_d = first_lat_q;
        last_isi_d  = last_isi_q;
        min_isi_d   = min_isi_q;
        peak_v_d    = peak_v_q;
        done_d      = 1'b0;

        v_s_d  = {neu_uo, neu_uio[7:1], 1'b0};
        sp_s_d = neu_uio[0];
        sp_d_d = sp_s_q;

        // Reads sample the current registers, so a read alongside start sees pre-clear data.
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? rd_byte : rd_data_q;

        if (start) begin
            elapsed_d   = '0;
            since_d     = 16'h0000;
            seen_d      = 1'b0;
            spike_cnt_d = 8'h00;
            first_lat_d = 16'hFFFF;
            last_isi_d  = 16'hFFFF;
            min_isi_d   = 16'hFFFF;
            peak_v_d    = 16'h0000;
            if (win_len != '0) begin
                remaining_d = win_len;
                state_d     = RUN;
            end else begin
                state_d = HOLD;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (elapsed_q != '1)       elapsed_d = elapsed_q + 1'b1;
                    if (since_q != 16'hFFFF)   since_d   = since_q + 16'd1;
                    remaining_d = remaining_q - 1'b1;
                    if (v_s_q > peak_v_q)      peak_v_d  = v_s_q;
                    if (spike_ev) begin
                        if (spike_cnt_q != 8'(CNT_MAX)) spike_cnt_d = spike_cnt_q + 8'd1;
                        if (!seen_q) begin
                            first_lat_d = 16'(elapsed_q);
                            seen_d      = 1'b1;
                        end else begin
                            last_isi_d = since_q;
                            if (since_q < min_isi_q) min_isi_d = since_q;
                        end
                        since_d = 16'd1;
                    end
                    if (remaining_q == 1) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
                IDLE, HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            v_s_q       <= 16'h0000;
            sp_s_q      <= 1'b0;
            sp_d_q      <= 1'b0;
            remaining_q <= '0;
            elapsed_q   <= '0;
            since_q     <= 16'h0000;
            seen_q      <= 1'b0;
            spike_cnt_q <= 8'h00;
            first_lat_q <= 16'hFFFF;
            last_isi_q  <= 16'hFFFF;
            min_isi_q   <= 16'hFFFF;
            peak_v_q    <= 16'h0000;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_s_q       <= v_s_d;
            sp_s_q      <= sp_s_d;
            sp_d_q      <= sp_d_d;
            remaining_q <= remaining_d;
            elapsed_q   <= elapsed_d;
            since_q     <= since_d;
            seen_q      <= seen_d;
            spike_cnt_q <= spike_cnt_d;
            first_lat_q <= first_lat_d;
            last_isi_q  <= last_isi_d;
            min_isi_q   <= min_isi_d;
            peak_v_q    <= peak_v_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_lif_output_monitor.sv
// Bench for lif_output_monitor: read expectations go into a scoreboard queue when the
// request is driven and are popped when rd_valid comes back.
module tb_lif_output_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  neu_uo;
    logic [7:0]  neu_uio;
    logic        start;
    logic [15:0] win_len;
    logic [3:0]  rd_addr;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;

    int          vectors = 0;
    int          miscompares = 0;
    logic        req_prev = 1'b0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    lif_output_monitor #(.WIN_W(16), .CNT_MAX(255)) dut (
        .clk(clk), .rst(rst), .neu_uo(neu_uo), .neu_uio(neu_uio),
        .start(start), .win_len(win_len), .rd_addr(rd_addr), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    // One clock; inputs change and outputs are checked at the falling edge.
    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        req_prev = rd_req;
        @(negedge clk);
        if (req_prev || rd_valid) begin
            vectors++;
            if (rd_valid !== req_prev) begin
                miscompares++;
                $display("FAIL rd_valid: got %b expected %b", rd_valid, req_prev);
            end
        end
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: got rd_valid=1 expected no pending read");
            end else begin
                e = sb.pop_front();
                vectors++;
                if (rd_data !== e[7:0]) begin
                    miscompares++;
                    $display("FAIL rd_data[addr %0d]: got %02h expected %02h", e[11:8], rd_data, e[7:0]);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read(input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        rd_req  = 1'b1;
        sb.push_back({a, exp});
        tick();
        rd_req = 1'b0;
    endtask

    task automatic set_pins(input logic [7:0] uo, input logic [7:0] uio);
        neu_uo  = uo;
        neu_uio = uio;
    endtask

    task automatic begin_window(input logic [15:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b vld=%b data=%02h expected 0 0 0 00",
                     busy, done, rd_valid, rd_data);
        end
        set_pins(8'h00, 8'h00);
        begin_window(16'd100);
        for (int c = 0; c < 20; c++) begin
            set_pins(8'h00, {7'h00, c == 4});
            tick();
        end
        read(4'd2, 8'h05);
        read(4'd0, 8'h01);
        rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b vld=%b data=%02h expected 0 0 0 00",
                     busy, done, rd_valid, rd_data);
        end
        ticks(2);
        rst = 1'b1;
        tick();
        read(4'd0, 8'h00);
        for (int a = 1; a <= 6; a++) read(4'(a), 8'hFF);
        read(4'd7, 8'h00);
        read(4'd8, 8'h00);
        read(4'd9, 8'h00);
    endtask

    task automatic test_spike_timing();
        int busy_cycles = 0;
        set_pins(8'h00, 8'h00);
        begin_window(16'd100);
        for (int c = 0; c < 100; c++) begin
            if (busy === 1'b1) busy_cycles++;
            set_pins(8'h00, {7'h00, (c + 1 == 10) || (c + 1 == 25) || (c + 1 == 33)});
            tick();
        end
        vectors++;
        if (busy_cycles != 100) begin
            miscompares++;
            $display("FAIL busy_len: got %0d expected 100", busy_cycles);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL window_end: got done=%b busy=%b expected 1 0", done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got %b expected 0", done);
        end
        read(4'd0, 8'd3);
        read(4'd1, 8'h00);
        read(4'd2, 8'd10);
        read(4'd3, 8'h00);
        read(4'd4, 8'd8);
        read(4'd5, 8'h00);
        read(4'd6, 8'd8);
        read(4'd9, 8'h05);
    endtask

    task automatic test_held_saturation();
        set_pins(8'h00, 8'h00);
        begin_window(16'd1000);
        set_pins(8'h00, 8'h01);
        ticks(20);
        set_pins(8'h00, 8'h00);
        ticks(3);
        read(4'd0, 8'd1);
        read(4'd9, 8'h06);
        for (int i = 0; i < 600; i++) begin
            set_pins(8'h00, {7'h00, i[0]});
            tick();
        end
        set_pins(8'h00, 8'h00);
        ticks(2);
        read(4'd0, 8'd255);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_busy: got %b expected 1", busy);
        end
    endtask

    task automatic test_peak();
        set_pins(8'h00, 8'h00);
        begin_window(16'd10);
        set_pins(8'h12, 8'h34); tick();
        set_pins(8'hC4, 8'hFF); tick();
        set_pins(8'h80, 8'h00); tick();
        set_pins(8'h00, 8'h00);
        ticks(7);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL peak_window_end: got done=%b busy=%b expected 1 0", done, busy);
        end
        read(4'd7, 8'hC4);
        read(4'd8, 8'hFE);
        read(4'd0, 8'd1);
        read(4'd2, 8'd2);
    endtask

    task automatic test_boundary();
        // Zero-length window
        set_pins(8'h00, 8'h00);
        begin_window(16'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_win: got done=%b busy=%b expected 1 0", done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_win_after: got done=%b busy=%b expected 0 0", done, busy);
        end
        read(4'd9, 8'h01);
        read(4'd0, 8'h00);
        read(4'd7, 8'h00);
        read(4'd12, 8'h00);
        read(4'd1, 8'hFF);
        tick();
        vectors++;
        if (rd_data !== 8'hFF || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_hold: got data=%02h vld=%b expected ff 0", rd_data, rd_valid);
        end

        // Restart mid-window with a coincident read
        begin_window(16'd50);
        for (int c = 0; c < 20; c++) begin
            set_pins(8'h00, {7'h00, c == 4});
            tick();
        end
        rd_addr = 4'd0;
        rd_req  = 1'b1;
        sb.push_back({4'd0, 8'h01});
        begin_window(16'd30);
        rd_req = 1'b0;
        read(4'd0, 8'h00);
        read(4'd1, 8'hFF);
        read(4'd9, 8'h02);
        ticks(27);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_end: got done=%b busy=%b expected 1 0", done, busy);
        end

        // Activity in HOLD must not disturb frozen results
        for (int i = 0; i < 10; i++) begin
            set_pins(8'hFF, {7'h7F, i[0]});
            tick();
        end
        set_pins(8'h00, 8'h00);
        ticks(2);
        read(4'd0, 8'h00);
        read(4'd7, 8'h00);
        read(4'd8, 8'h00);
        read(4'd2, 8'hFF);
        read(4'd9, 8'h01);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        win_len = 16'd0;
        rd_addr = 4'd0;
        rd_req = 1'b0;
        set_pins(8'h00, 8'h00);
        ticks(3);
        rst = 1'b1;
        tick();
        test_reset();
        test_spike_timing();
        test_held_saturation();
        test_peak();
        test_boundary();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_output_monitor.md
Name: lif_output_monitor

Overview:
- Reader-side companion to LIF_neuron. Samples the neuron's output pins (uo_out, uio_out) and reconstructs the 16-bit membrane voltage and the spike flag.
- Over a programmable observation window it measures:
  - spike count
  - first-spike latency
  - last and minimum inter-spike interval (ISI)
  - peak membrane voltage
- Results are frozen at window end and read out byte-wise through a registered address/data port. Sits between the neuron and the on-chip or host readout logic.

Parameters:
- WIN_W, 16: width of the window-length input and the elapsed-cycle counter.
- CNT_MAX, 255: saturation value of the spike counter (fits 8 bits).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- neu_uo  input  8  neuron uo_out (vout[15:8]).
- neu_uio  input  8  neuron uio_out ([7:1] = vout[7:1], [0] = spike).
- start  input  1  1-cycle pulse; clears results and begins a window.
- win_len  input  WIN_W  window length in cycles, sampled on start.
- rd_addr  input  4  result byte select.
- rd_req  input  1  read strobe.
- rd_data  output  8  selected result byte.
- rd_valid  output  1  high 1 cycle after rd_req.
- busy  output  1  high while in RUN.
- done  output  1  1-cycle pulse on window completion.

Behaviour:
- Input stage: registers every cycle, independent of state.
  - v_s = {neu_uo, neu_uio[7:1], 1'b0}
  - sp_s = neu_uio[0]
  - sp_d = previous sp_s
  - A spike event is sp_s & ~sp_d, i.e. rising edges only; a held-high spike counts once.
- FSM states IDLE, RUN, HOLD. Reset puts the FSM in IDLE.
- Reset values: rd_data=0x00, rd_valid=0, busy=0, done=0, spike_cnt=0, first_lat=0xFFFF, last_isi=0xFFFF, min_isi=0xFFFF, peak_v=0x0000, elapsed=0, since=0, seen=0.
- start in any state (including RUN, HOLD, or mid-window) clears all results to their reset values.
  - win_len != 0: load remaining=win_len and enter RUN on the next cycle.
  - win_len == 0: go straight to HOLD and pulse done on the next cycle; results keep their cleared values.
- RUN, each cycle:
  - elapsed increments, saturating at 0xFFFF.
  - since increments, saturating at 0xFFFF.
  - remaining decrements.
  - peak_v = max(peak_v, v_s), unsigned compare.
- On a spike event in RUN:
  - spike_cnt increments, saturating at CNT_MAX.
  - If seen == 0: first_lat = elapsed, seen = 1.
  - If seen == 1: last_isi = since, and min_isi = min(min_isi, since).
  - since is reset to 1. The same-cycle increment is overridden.
- Window end: when remaining == 1, the following cycle enters HOLD and done pulses for exactly 1 cycle. RUN lasts exactly win_len cycles.
- busy = (state == RUN).
- Spike events are ignored in IDLE and HOLD; results stay frozen until the next start.
- Readout:
  - rd_req in any state: next cycle rd_valid = 1 and rd_data = the byte selected by rd_addr, taken from register values present on the request cycle.
  - If rd_req coincides with start, the read returns the pre-clear values.
  - Address map:
    - 0: spike_cnt
    - 1/2: first_lat hi/lo
    - 3/4: last_isi hi/lo
    - 5/6: min_isi hi/lo
    - 7/8: peak_v hi/lo
    - 9: {5'b0, seen, busy, state == HOLD}
    - 10–15: 0x00
  - rd_data holds its value when rd_req is low.
- Async reset mid-window: the FSM returns to IDLE immediately and all outputs take their reset values.

Test Plan:
- Reset/readout: assert rst=0 mid-RUN, release, read addr 0..9 → 0x00, 0xFF, 0xFF, 0xFF, 0xFF, 0xFF, 0xFF, 0x00, 0x00, 0x00; rd_valid high exactly 1 cycle after each rd_req.
- Spike timing: start with win_len=100; raise spike for 1 cycle at RUN cycles 10, 25 and 33 → spike_cnt=3, first_lat=10, last_isi=8, min_isi=8 (ISIs 15 and 8); done pulses 1 cycle after cycle 100; busy high for 100 cycles.
- Held spike and saturation: spike held high for 20 cycles → count +1 only. A 1-cycle toggle every other cycle for 600 cycles → spike_cnt=255, no wrap.
- Peak voltage: drive vout sequence 0x1234, 0xC4FE, 0x8000 → peak_v=0xC4FE, i.e. addr7=0xC4, addr8=0xFE; vout bit0 always reads 0.
- Boundary: start with win_len=0 → done next cycle, busy never high. start during RUN restarts with cleared results. rd_req coincident with start returns old spike_cnt. Spikes arriving in HOLD leave results unchanged.
